// File: rtl/platform_pkg.sv
// Shared types and constant platform geometry for the floor-lookup engine.
package platform_pkg;

  localparam int PLAT_ENTRIES = 8;
  localparam logic [9:0] SCREEN_BOTTOM = 10'd479;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] w;
    logic [9:0] h;
  } plat_t;

  typedef plat_t [PLAT_ENTRIES-1:0] plat_tbl_t;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  // Unused slots sit off-screen with zero width so they can never become the floor.
  function automatic plat_tbl_t default_plat_table();
    plat_tbl_t t;
    for (int i = 0; i < PLAT_ENTRIES; i++) t[i] = '{x: 10'd0, y: 10'd600, w: 10'd0, h: 10'd0};
    t[0] = '{x: 10'd200, y: 10'd380, w: 10'd50, h: 10'd5};
    t[1] = '{x: 10'd400, y: 10'd400, w: 10'd30, h: 10'd5};
    t[2] = '{x: 10'd220, y: 10'd300, w: 10'd40, h: 10'd5};
    return t;
  endfunction

  localparam plat_tbl_t PLAT_TABLE = default_plat_table();

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational grant from a rotating pointer, pointer
// advances past the served requester when told to.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic [N-1:0]  req,
  input  logic          advance,
  input  logic [IW-1:0] served_idx,
  output logic [N-1:0]  grant_oh,
  output logic [IW-1:0] grant_idx,
  output logic          grant_valid
);

  logic [IW-1:0] ptr_reg;
  logic [IW:0]   cand_sum;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      ptr_reg <= '0;
    end else if (advance) begin
      ptr_reg <= (served_idx == IW'(N - 1)) ? '0 : served_idx + 1'b1;
    end
  end

  // Scan offsets from the pointer, wrapping modulo N; first hit wins.
  always_comb begin
    grant_oh    = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand_sum    = '0;
    for (int k = 0; k < N; k++) begin
      cand_sum = {1'b0, ptr_reg} + k[IW:0];
      if (cand_sum >= (IW+1)'(N)) cand_sum = cand_sum - (IW+1)'(N);
      if (!grant_valid && req[cand_sum[IW-1:0]]) begin
        grant_valid                = 1'b1;
        grant_idx                  = cand_sum[IW-1:0];
        grant_oh[cand_sum[IW-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/platform_floor_scheduler.sv
// Shared floor-lookup engine: one comparator walks the platform table per granted
// requester. Optional hit reporting is enabled with PLATFORM_HIT_INFO_EN.
module platform_floor_scheduler #(
  parameter int NREQ = 4,
  parameter int NPLAT = 8,
  parameter logic [9:0] SCREEN_BOTTOM = platform_pkg::SCREEN_BOTTOM,
  parameter platform_pkg::plat_tbl_t PLAT_TABLE_P = platform_pkg::PLAT_TABLE,
  localparam int IDXW = (NPLAT > 1) ? $clog2(NPLAT) : 1,
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ*10-1:0] obj_x_i,
  input  logic [NREQ*10-1:0] obj_y_i,
  input  logic [NREQ*10-1:0] obj_s_i,
  output logic [NREQ-1:0]    done_o,
  output logic [9:0]         y_max_o,
  output logic               busy_o
`ifdef PLATFORM_HIT_INFO_EN
  ,
  output logic               hit_o,
  output logic [IDXW-1:0]    hit_idx_o
`endif
);
  import platform_pkg::*;

  state_t          state_reg;
  logic [NREQ-1:0] gnt_oh_reg;
  logic [GW-1:0]   gnt_idx_reg;
  logic [9:0]      x_reg, y_reg, s_reg, best_reg;
  logic [IDXW-1:0] idx_reg;

  logic [9:0]      x_arr [NREQ];
  logic [9:0]      y_arr [NREQ];
  logic [9:0]      s_arr [NREQ];

  logic [NREQ-1:0] arb_oh;
  logic [GW-1:0]   arb_idx;
  logic            arb_valid;
  logic            arb_advance;

  plat_t              ent;
  logic signed [11:0] ox, oy, os, px, py, pw, ph, top;
  logic               qual, better;
  logic [9:0]         best_next;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign x_arr[gi] = obj_x_i[10*gi +: 10];
      assign y_arr[gi] = obj_y_i[10*gi +: 10];
      assign s_arr[gi] = obj_s_i[10*gi +: 10];
    end
  endgenerate

  assign arb_advance = (state_reg == DONE);

  rr_arbiter #(.N(NREQ)) u_arb (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .req         (req_i),
    .advance     (arb_advance),
    .served_idx  (gnt_idx_reg),
    .grant_oh    (arb_oh),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  // Zero-extend to 12-bit signed so x-s and px-pw go negative instead of wrapping.
  assign ent = PLAT_TABLE_P[idx_reg];
  assign ox  = $signed({2'b00, x_reg});
  assign oy  = $signed({2'b00, y_reg});
  assign os  = $signed({2'b00, s_reg});
  assign px  = $signed({2'b00, ent.x});
  assign py  = $signed({2'b00, ent.y});
  assign pw  = $signed({2'b00, ent.w});
  assign ph  = $signed({2'b00, ent.h});
  assign top = py - ph;

  assign qual      = ((ox + os) >= (px - pw)) && ((ox - os) <= (px + pw)) && ((oy + os) <= top);
  assign better    = qual && (top < $signed({2'b00, best_reg}));
  assign best_next = better ? top[9:0] : best_reg;

`ifdef PLATFORM_HIT_INFO_EN
  logic            hit_run_reg;
  logic [IDXW-1:0] hit_idx_run_reg;
`endif

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_reg   <= IDLE;
      gnt_oh_reg  <= '0;
      gnt_idx_reg <= '0;
      x_reg       <= '0;
      y_reg       <= '0;
      s_reg       <= '0;
      best_reg    <= SCREEN_BOTTOM;
      idx_reg     <= '0;
      done_o      <= '0;
      y_max_o     <= SCREEN_BOTTOM;
      busy_o      <= 1'b0;
`ifdef PLATFORM_HIT_INFO_EN
      hit_run_reg     <= 1'b0;
      hit_idx_run_reg <= '0;
      hit_o           <= 1'b0;
      hit_idx_o       <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          done_o <= '0;
          if (arb_valid) begin
            gnt_oh_reg  <= arb_oh;
            gnt_idx_reg <= arb_idx;
            x_reg       <= x_arr[arb_idx];
            y_reg       <= y_arr[arb_idx];
            s_reg       <= s_arr[arb_idx];
            best_reg    <= SCREEN_BOTTOM;
            idx_reg     <= '0;
            busy_o      <= 1'b1;
            state_reg   <= SCAN;
`ifdef PLATFORM_HIT_INFO_EN
            hit_run_reg     <= 1'b0;
            hit_idx_run_reg <= '0;
`endif
          end
        end
        SCAN: begin
          best_reg <= best_next;
          idx_reg  <= idx_reg + 1'b1;
`ifdef PLATFORM_HIT_INFO_EN
          if (better) begin
            hit_run_reg     <= 1'b1;
            hit_idx_run_reg <= idx_reg;
          end
`endif
          // Results are registered on the last entry so they are visible during DONE.
          if (idx_reg == IDXW'(NPLAT - 1)) begin
            idx_reg   <= '0;
            y_max_o   <= best_next;
            done_o    <= gnt_oh_reg;
            state_reg <= DONE;
`ifdef PLATFORM_HIT_INFO_EN
            hit_o     <= hit_run_reg | better;
            hit_idx_o <= better ? idx_reg : hit_idx_run_reg;
`endif
          end
        end
        DONE: begin
          done_o    <= '0;
          busy_o    <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_platform_floor_scheduler.sv
// Directed bench for platform_floor_scheduler with hand-computed landing heights.
module tb_platform_floor_scheduler;
  import platform_pkg::*;

  localparam int NREQ   = 4;
  localparam int NPLAT  = 8;
  localparam int LAT    = NPLAT + 1;
  localparam int PERIOD = NPLAT + 2;
  localparam int TMO    = 40;

  // Default table plus a platform near the left edge for the underflow case.
  function automatic plat_tbl_t tb_table();
    plat_tbl_t t;
    t = PLAT_TABLE;
    t[3] = '{x: 10'd20, y: 10'd380, w: 10'd30, h: 10'd5};
    return t;
  endfunction
  localparam plat_tbl_t TB_TABLE = tb_table();

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [3:0]  req = '0;
  logic [39:0] ox = '0, oy = '0, os = '0;
  logic [3:0]  done;
  logic [9:0]  y_max;
  logic        busy;
`ifdef PLATFORM_HIT_INFO_EN
  logic        hit;
  logic [2:0]  hit_idx;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 Clk = ~Clk;

  platform_floor_scheduler #(
    .NREQ         (NREQ),
    .NPLAT        (NPLAT),
    .PLAT_TABLE_P (TB_TABLE)
  ) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .req_i   (req),
    .obj_x_i (ox),
    .obj_y_i (oy),
    .obj_s_i (os),
    .done_o  (done),
    .y_max_o (y_max),
    .busy_o  (busy)
`ifdef PLATFORM_HIT_INFO_EN
    ,
    .hit_o     (hit),
    .hit_idx_o (hit_idx)
`endif
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic set_obj(input int k, input int x, input int y, input int s);
    ox[10*k +: 10] = 10'(x);
    oy[10*k +: 10] = 10'(y);
    os[10*k +: 10] = 10'(s);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (done == 4'b0000 && n < TMO);
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    req = '0;
    step(2);
    Reset_n = 1'b1;
  endtask

  task automatic count_dones(input int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin
      step(1);
      if (done != 4'b0000) cnt++;
    end
  endtask

  // Single-requester lookup: latency, done bit, result, then the cycle after done.
  task automatic lookup(input string tag, input int k, input int x, input int y,
                        input int s, input int expy);
    int n;
    set_obj(k, x, y, s);
    req[k] = 1'b1;
    wait_done(n);
    check_eq({tag, " latency"}, n, LAT);
    check_eq({tag, " done"}, int'(done), 1 << k);
    check_eq({tag, " y_max"}, int'(y_max), expy);
    $display("lookup %s: req=%0d x=%0d y=%0d s=%0d -> y_max=%0d after %0d cycles",
             tag, k, x, y, s, y_max, n);
    req[k] = 1'b0;
    step(1);
    check_eq({tag, " idle"}, int'({busy, done}), 0);
    check_eq({tag, " hold"}, int'(y_max), expy);
  endtask

  initial begin
    int n;
    int cnt;
    int ord_a[4] = '{0, 2, 0, 2};
    int y_a[4]   = '{375, 479, 375, 479};
    int ord_b[3] = '{0, 1, 2};
    int y_b[3]   = '{375, 395, 479};

    Reset_n = 1'b0;
    step(2);
    check_eq("reset y_max", int'(y_max), 479);
    check_eq("reset done", int'(done), 0);
    check_eq("reset busy", int'(busy), 0);
    $display("reset: y_max=%0d done=%0d busy=%0d", y_max, done, busy);
    Reset_n = 1'b1;

    // Bottom 316 lies below platform 2 (top 295), so only platform 0 (top 375) qualifies.
    lookup("floor_e0", 0, 210, 300, 16, 375);
    lookup("floor_e2", 1, 210, 270, 16, 295);
    lookup("floor_y350", 2, 210, 350, 16, 375);
    lookup("edge_touch", 3, 210, 359, 16, 375);
    lookup("edge_x", 0, 134, 300, 16, 375);
    lookup("floor_e1", 1, 400, 380, 10, 395);
    lookup("miss_x", 2, 600, 300, 16, 479);
    lookup("miss_below", 3, 210, 370, 10, 479);
    lookup("underflow", 0, 5, 300, 16, 375);

    // Two requesters held continuously alternate 0,2,0,2.
    do_reset();
    set_obj(0, 210, 300, 16);
    set_obj(2, 600, 300, 16);
    req = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      wait_done(n);
      check_eq($sformatf("arbA%0d spacing", i), n, (i == 0) ? LAT : PERIOD);
      check_eq($sformatf("arbA%0d done", i), int'(done), 1 << ord_a[i]);
      check_eq($sformatf("arbA%0d y_max", i), int'(y_max), y_a[i]);
      $display("arbA %0d: done=%b y_max=%0d gap=%0d", i, done, y_max, n);
    end
    req = '0;
    step(1);

    // Requester 1 joins after the first done; pointer has moved past 0 so it goes next.
    do_reset();
    set_obj(1, 400, 380, 10);
    req = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      wait_done(n);
      check_eq($sformatf("arbB%0d spacing", i), n, (i == 0) ? LAT : PERIOD);
      check_eq($sformatf("arbB%0d done", i), int'(done), 1 << ord_b[i]);
      check_eq($sformatf("arbB%0d y_max", i), int'(y_max), y_b[i]);
      $display("arbB %0d: done=%b y_max=%0d gap=%0d", i, done, y_max, n);
      if (i == 0) req[1] = 1'b1;
    end
    req = '0;
    step(1);

    // Request dropped and inputs changed mid-scan: lookup completes on latched values.
    do_reset();
    set_obj(0, 210, 300, 16);
    req[0] = 1'b1;
    step(3);
    req[0] = 1'b0;
    set_obj(0, 600, 300, 16);
    wait_done(n);
    check_eq("drop latency", n, LAT - 3);
    check_eq("drop done", int'(done), 1);
    check_eq("drop y_max", int'(y_max), 375);
    count_dones(20, cnt);
    check_eq("drop single pulse", cnt, 0);
    $display("drop: y_max=%0d extra_dones=%0d", y_max, cnt);

    // Reset while entry 3 is being evaluated abandons the lookup.
    set_obj(0, 210, 270, 16);
    req[0] = 1'b1;
    step(4);
    check_eq("midrst busy before", int'(busy), 1);
    Reset_n = 1'b0;
    req[0] = 1'b0;
    step(1);
    check_eq("midrst done", int'(done), 0);
    check_eq("midrst busy", int'(busy), 0);
    check_eq("midrst y_max", int'(y_max), 479);
    Reset_n = 1'b1;
    count_dones(20, cnt);
    check_eq("midrst no done", cnt, 0);
    $display("midrst: y_max=%0d busy=%0d dones=%0d", y_max, busy, cnt);
    lookup("after_rst", 2, 210, 270, 16, 295);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
